// File: rtl/stream_aggregator.sv
// stream_aggregator: packs FETCH_WIDTH sender words into one wide receiver vector
// Ports: clk, rst (sync, active-high); sender_data/sender_empty_n/sender_deq (FWFT word side);
// receiver_data/receiver_full_n/receiver_enq (wide vector side); flush only with AGGREGATOR_FLUSH_EN.
module stream_aggregator #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef AGGREGATOR_FLUSH_EN
  input  logic                              flush,
`endif
  input  logic [DATA_WIDTH-1:0]             sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq
);
  localparam int CW = $clog2(FETCH_WIDTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FETCH_WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] data_q, data_d;
  logic full, flush_act;
  assign receiver_data = data_q;
  always_comb begin
    full = cnt_q == FULL_CNT;
`ifdef AGGREGATOR_FLUSH_EN
    flush_act = flush && cnt_q != '0 && !full;
`else
    flush_act = 1'b0;
`endif
    receiver_enq = !rst && full && receiver_full_n;
    sender_deq = !rst && sender_empty_n && (!full || receiver_full_n) && !flush_act;
    cnt_d = cnt_q;
    data_d = data_q;
    if (flush_act) begin
      cnt_d = FULL_CNT;
      for (int k = 0; k < FETCH_WIDTH; k++)
        if (CW'(k) >= cnt_q) data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else if (receiver_enq) begin
      // draining and refilling on the same edge starts the next group at lane 0
      cnt_d = sender_deq ? CW'(1) : '0;
      if (sender_deq) data_d[DATA_WIDTH-1:0] = sender_data;
    end else if (sender_deq) begin
      cnt_d = cnt_q + CW'(1);
      for (int k = 0; k < FETCH_WIDTH; k++)
        if (CW'(k) == cnt_q) data_d[k*DATA_WIDTH +: DATA_WIDTH] = sender_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_stream_aggregator.sv
// tb_stream_aggregator: vector table, corner sequences and randomized model check
module tb_stream_aggregator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, fn, deq, enq, en4, fn4, deq4, enq4, flush, flush4;
  logic [7:0] sd, sd4;
  logic [15:0] rd;
  logic [31:0] rd4;
  int nvec = 0, nerr = 0;

  stream_aggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(2)) u2 (
    .clk(clk), .rst(rst),
`ifdef AGGREGATOR_FLUSH_EN
    .flush(flush),
`endif
    .sender_data(sd), .sender_empty_n(en), .sender_deq(deq),
    .receiver_data(rd), .receiver_full_n(fn), .receiver_enq(enq));

  stream_aggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
`ifdef AGGREGATOR_FLUSH_EN
    .flush(flush4),
`endif
    .sender_data(sd4), .sender_empty_n(en4), .sender_deq(deq4),
    .receiver_data(rd4), .receiver_full_n(fn4), .receiver_enq(enq4));

  typedef struct packed {
    logic r; logic e; logic [7:0] d; logic f;
    logic x_deq; logic x_enq; logic cd; logic [15:0] x_data;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [7:0] mq[$];
  logic [7:0] nw;
  logic full_m, x_deq, x_enq;
  logic [15:0] xd, ad;

  initial begin
    rst = 1; en = 0; fn = 0; sd = 0; en4 = 0; fn4 = 0; sd4 = 0; flush = 0; flush4 = 0;
    //          r  e  d      f  deq enq cd data
    tbl[0]  = '{1, 1, 8'h05, 1, 0, 0, 0, 16'h0000};
    tbl[1]  = '{1, 1, 8'h05, 1, 0, 0, 1, 16'h0000};
    tbl[2]  = '{0, 1, 8'h00, 1, 1, 0, 1, 16'h0000};
    tbl[3]  = '{0, 1, 8'h01, 1, 1, 0, 1, 16'h0000};
    tbl[4]  = '{0, 1, 8'h02, 1, 1, 1, 1, 16'h0100};
    tbl[5]  = '{0, 1, 8'h03, 1, 1, 0, 1, 16'h0102};
    tbl[6]  = '{0, 1, 8'h04, 0, 0, 0, 1, 16'h0302};
    tbl[7]  = '{0, 1, 8'h04, 0, 0, 0, 1, 16'h0302};
    tbl[8]  = '{0, 1, 8'h04, 1, 1, 1, 1, 16'h0302};
    tbl[9]  = '{0, 0, 8'h99, 1, 0, 0, 1, 16'h0304};
    tbl[10] = '{0, 1, 8'h05, 1, 1, 0, 1, 16'h0304};
    tbl[11] = '{0, 0, 8'h00, 1, 0, 1, 1, 16'h0504};
    tbl[12] = '{0, 1, 8'h0A, 0, 1, 0, 1, 16'h0504};
    tbl[13] = '{1, 1, 8'h0B, 1, 0, 0, 1, 16'h050A};
    tbl[14] = '{0, 1, 8'h0A, 1, 1, 0, 1, 16'h0000};
    tbl[15] = '{0, 1, 8'h0B, 1, 1, 0, 1, 16'h000A};
    tbl[16] = '{0, 0, 8'h00, 1, 0, 1, 1, 16'h0B0A};
    tbl[17] = '{0, 0, 8'h00, 1, 0, 0, 1, 16'h0B0A};
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = tbl[i].r; en = tbl[i].e; sd = tbl[i].d; fn = tbl[i].f;
      #1;
      chk($sformatf("tbl[%0d]", i), {deq, enq, tbl[i].cd ? rd : 16'h0},
          {tbl[i].x_deq, tbl[i].x_enq, tbl[i].x_data});
    end
    // held full vector under 5 cycles of backpressure, then release with same-cycle refill
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      en = c < 8; fn = c >= 7;
      sd = c == 0 ? 8'h20 : c == 1 ? 8'h21 : 8'h22;
      #1;
      xd = c < 2 ? 16'h0 : c == 8 ? 16'h0022 : 16'h2120;
      ad = c < 2 ? 16'h0 : c == 8 ? {8'h0, rd[7:0]} : rd;
      chk($sformatf("hold[%0d]", c), {deq, enq, ad}, {c < 2 || c == 7, c == 7, xd});
    end
    // FETCH_WIDTH=4 continuous stream 0..7
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      en4 = c < 8; sd4 = 8'(c); fn4 = 1;
      #1;
      chk($sformatf("fw4[%0d]", c), {deq4, enq4, enq4 ? rd4 : 32'h0},
          {c < 8, c == 4 || c == 8, c == 4 ? 32'h03020100 : c == 8 ? 32'h07060504 : 32'h0});
    end
    en4 = 0;
    // randomized stalls on both sides against a queue model of collected words
    mq = '{8'h22};
    nw = 8'h23;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      en = $urandom_range(0, 3) != 0;
      fn = $urandom_range(0, 1) == 1;
      sd = en ? nw : 8'($urandom);
      full_m = mq.size() == 2;
      x_enq = full_m && fn;
      x_deq = en && (!full_m || fn);
      xd = full_m ? {mq[1], mq[0]} : 16'h0;
      #1;
      chk($sformatf("rnd[%0d]", c), {deq, enq, full_m ? rd : 16'h0}, {x_deq, x_enq, xd});
      if (x_enq) mq.delete();
      if (x_deq) begin
        mq.push_back(nw);
        nw++;
      end
    end
`ifdef AGGREGATOR_FLUSH_EN
    @(negedge clk);
    rst = 1; en = 0; fn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rst = 0;
      en = c < 2 || c == 3 || c == 4;
      sd = c == 0 ? 8'h11 : c == 1 ? 8'h22 : c == 3 ? 8'h2A : 8'h55;
      fn = c >= 2;
      flush = c == 4;
      #1;
      xd = c == 2 ? 16'h2211 : c == 4 ? 16'h222A : c == 5 ? 16'h002A : 16'h0;
      chk($sformatf("flush[%0d]", c), {deq, enq, (c == 2 || c >= 4) ? rd : 16'h0},
          {c < 2 || c == 3, c == 2 || c == 5, xd});
    end
    flush = 0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
